led_mode_sequencer: RTL
=======================

LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYC, default 48, giving the number of consecutive stable samples (~20 ms at 2.4 kHz) before a button level is accepted.
REQ-002 The block SHALL have parameter AUTO_PERIOD, default 24000, giving the number of RUN cycles (~10 s) before an auto-advance.
REQ-003 The block SHALL have parameter BLANK_CYC, default 240, giving the number of all-off cycles (~0.1 s) inserted on every mode change.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 btn_next  in  1  raw asynchronous button, active-high; advances to the next mode.
REQ-007 btn_prev  in  1  raw asynchronous button, active-high; steps back to the previous mode.
REQ-008 auto_en  in  1  synchronous level; 1 enables timed auto-advance.
REQ-009 mode0_led, mode1_led, mode2_led, mode3_led  in  8 each  LED patterns from the four pattern drivers.
REQ-010 led_out  out  8  registered LED output.
REQ-011 mode_sel  out  2  currently selected mode index.
REQ-012 mode_rst_n  out  4  per-driver active-low reset; bit i controls driver i.
REQ-013 busy  out  1  1 while in BLANK state.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debounce counter that accepts a new level only after DEBOUNCE_CYC consecutive equal synchronized samples; any differing sample restarts the count.
REQ-015 A 0->1 transition of the debounced level SHALL produce a 1-cycle request pulse; release produces nothing, and holding produces exactly one pulse.
REQ-016 The FSM SHALL have two states, RUN and BLANK; reset enters RUN with mode_sel=0.
REQ-017 In RUN, a next pulse SHALL set target=(mode_sel+1) mod 4, and a prev pulse SHALL set target=(mode_sel-1) mod 4; mode index arithmetic is 2-bit with wrap (3->0 on next, 0->3 on prev).
REQ-018 Next and prev pulses in the same cycle SHALL cancel: no change, and the auto timer is not cleared.
REQ-019 In RUN with auto_en=1, a 0..AUTO_PERIOD-1 timer SHALL increment each cycle; on the cycle it equals AUTO_PERIOD-1 it SHALL generate an internal next request.
REQ-020 The auto timer SHALL be cleared when auto_en=0, in BLANK, and on any accepted button request.
REQ-021 A button request SHALL take priority over a same-cycle auto request; only one mode step occurs.
REQ-022 On an accepted request in RUN, the next cycle SHALL enter BLANK with mode_sel=target, busy=1, and the BLANK counter at 0.
REQ-023 In BLANK, led_out SHALL be 8'h00 and mode_rst_n SHALL be 4'b0000.
REQ-024 In BLANK, button and auto requests SHALL be discarded, not queued.
REQ-025 BLANK SHALL last exactly BLANK_CYC cycles, then return to RUN with busy=0.
REQ-026 In RUN, mode_rst_n SHALL have only bit mode_sel at 1, holding the idle drivers in reset so the selected pattern restarts from its beginning after every switch.
REQ-027 In RUN, led_out SHALL register the selected modeN_led, giving 1-cycle latency from driver output to led_out.
REQ-028 Re-selecting the same mode is impossible by construction; every accepted request changes mode_sel.

Reset
REQ-029 Asserting rst_n=0 at any time, including mid-BLANK or mid-debounce, SHALL immediately force: led_out=8'h00, mode_sel=0, mode_rst_n=4'b0001, busy=0, and all counters and synchronizer and debounce state to 0.
REQ-030 After rst_n deasserts, the first accepted button edge SHALL require a full DEBOUNCE_CYC of stable high.

Verification
REQ-031 Reset, then drive mode0_led=8'h01 with auto_en=0 -> mode_sel=0, mode_rst_n=4'b0001, led_out=8'h01 one cycle after input, busy=0.
REQ-032 Hold btn_next high 100 cycles with a glitch of 10 cycles low at the start -> exactly one switch; mode_sel=1; busy=1 for exactly 240 cycles with led_out=0 and mode_rst_n=0; then mode_rst_n=4'b0010.
REQ-033 From mode_sel=0, press btn_prev cleanly -> mode_sel=3 after BLANK; from mode 3, btn_next -> mode_sel=0.
REQ-034 auto_en=1, no buttons -> mode advances every 24000+240 cycles (0->1->2->3->0); toggling auto_en low for 1 cycle restarts the 24000 count.
REQ-035 Press btn_next and btn_prev with identical timing -> no mode change; press btn_next during BLANK -> ignored, mode_sel advances only once.
REQ-036 Pulse rst_n low mid-BLANK with mode_sel=2 -> outputs immediately at reset values; after release, RUN in mode 0.

Source files
------------

// File: rtl/led_mode_if.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : led_mode_if
// Brief    : Bus between the LED mode sequencer and the four pattern
//            drivers: pattern inputs, selected LED output, mode index,
//            per-driver resets and the blanking indicator.
// Revision : 1.0 - initial release
//============================================================================
interface led_mode_if;

  // Pattern driver outputs, one byte per mode
  logic [7:0] mode0_led;
  logic [7:0] mode1_led;
  logic [7:0] mode2_led;
  logic [7:0] mode3_led;

  // Sequencer outputs
  logic [7:0] led_out;
  logic [1:0] mode_sel;
  logic [3:0] mode_rst_n;
  logic       busy;

  // Sequencer side: consumes the patterns, drives the selection
  modport master (
    input  mode0_led,
    input  mode1_led,
    input  mode2_led,
    input  mode3_led,
    output led_out,
    output mode_sel,
    output mode_rst_n,
    output busy
  );

  // Driver / observer side
  modport slave (
    output mode0_led,
    output mode1_led,
    output mode2_led,
    output mode3_led,
    input  led_out,
    input  mode_sel,
    input  mode_rst_n,
    input  busy
  );

endinterface : led_mode_if
`default_nettype wire

// File: rtl/led_mode_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : led_mode_sequencer
// Brief    : Selects one of four LED pattern drivers. Two debounced push
//            buttons step the mode forward/back, an optional timer
//            auto-advances it, and every mode change inserts an all-off
//            blanking interval while all drivers are held in reset.
// Revision : 1.0 - initial release
//============================================================================
module led_mode_sequencer #(
  parameter int DEBOUNCE_CYC = 48,     // stable samples before a button level is accepted
  parameter int AUTO_PERIOD  = 24000,  // RUN cycles between auto-advances
  parameter int BLANK_CYC    = 240     // all-off cycles inserted on every mode change
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  input  wire logic  btn_next_i,
  input  wire logic  btn_prev_i,
  input  wire logic  auto_en_i,
  led_mode_if.master led_bus
);

  //--------------------------------------------------------------------------
  // Counter widths and terminal values
  //--------------------------------------------------------------------------
  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int AT_W = (AUTO_PERIOD  > 1) ? $clog2(AUTO_PERIOD)  : 1;
  localparam int BL_W = (BLANK_CYC    > 1) ? $clog2(BLANK_CYC)    : 1;

  localparam logic [DB_W-1:0] C_DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [AT_W-1:0] C_AUTO_LAST  = AT_W'(AUTO_PERIOD - 1);
  localparam logic [BL_W-1:0] C_BLANK_LAST = BL_W'(BLANK_CYC - 1);

  //--------------------------------------------------------------------------
  // FSM encoding
  //--------------------------------------------------------------------------
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  //--------------------------------------------------------------------------
  // Button conditioning: bit 0 = next, bit 1 = prev
  //--------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] btn_req;   // single-cycle press pulses

  assign btn_raw = {btn_prev_i, btn_next_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync1_q;
      logic            sync2_q;
      logic            level_q;
      logic            level_d;
      logic            level_dly_q;
      logic [DB_W-1:0] cnt_q;
      logic [DB_W-1:0] cnt_d;

      // Count consecutive synchronized samples that disagree with the accepted
      // level; a sample that agrees restarts the count. On the last required
      // sample the new level is accepted and the count returns to zero.
      always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
          if (cnt_q == C_DB_LAST) begin
            level_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Two-flop synchronizer, debounce state and edge-detect delay
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q     <= 1'b0;
          sync2_q     <= 1'b0;
          level_q     <= 1'b0;
          level_dly_q <= 1'b0;
          cnt_q       <= '0;
        end else begin
          sync1_q     <= btn_raw[gi];
          sync2_q     <= sync1_q;
          level_q     <= level_d;
          level_dly_q <= level_q;
          cnt_q       <= cnt_d;
        end
      end

      // Press edge only; release and continued holding produce nothing
      assign btn_req[gi] = level_q & ~level_dly_q;
    end
  endgenerate

  //--------------------------------------------------------------------------
  // Mode FSM
  //--------------------------------------------------------------------------
  logic [0:0]      state_q;
  logic [0:0]      state_d;
  logic [1:0]      mode_q;
  logic [1:0]      mode_d;
  logic [AT_W-1:0] auto_cnt_q;
  logic [AT_W-1:0] auto_cnt_d;
  logic [BL_W-1:0] blank_cnt_q;
  logic [BL_W-1:0] blank_cnt_d;
  logic [7:0]      led_q;
  logic [7:0]      led_d;

  logic            btn_accept;   // exactly one of next/prev pressed this cycle
  logic [1:0]      btn_target;

  // Simultaneous next and prev cancel each other out
  assign btn_accept = btn_req[0] ^ btn_req[1];
  assign btn_target = btn_req[0] ? (mode_q + 2'd1) : (mode_q - 2'd1);

  // Next-state logic: button steps beat the auto timer; BLANK discards all
  // requests and just counts out its fixed length.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    auto_cnt_d  = auto_cnt_q;
    blank_cnt_d = blank_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (btn_accept) begin
          state_d     = ST_BLANK;
          mode_d      = btn_target;
          auto_cnt_d  = '0;
          blank_cnt_d = '0;
        end else if (!auto_en_i) begin
          auto_cnt_d  = '0;
        end else if (auto_cnt_q == C_AUTO_LAST) begin
          state_d     = ST_BLANK;
          mode_d      = mode_q + 2'd1;
          auto_cnt_d  = '0;
          blank_cnt_d = '0;
        end else begin
          auto_cnt_d  = auto_cnt_q + 1'b1;
        end
      end

      default: begin
        auto_cnt_d = '0;
        if (blank_cnt_q == C_BLANK_LAST) begin
          state_d     = ST_RUN;
          blank_cnt_d = '0;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // LED output follows the state being entered, so BLANK is dark from its
  // first cycle and RUN shows the selected driver one cycle late.
  always_comb begin
    led_d = 8'h00;
    if (state_d == ST_RUN) begin
      case (mode_d)
        2'd0:    led_d = led_bus.mode0_led;
        2'd1:    led_d = led_bus.mode1_led;
        2'd2:    led_d = led_bus.mode2_led;
        default: led_d = led_bus.mode3_led;
      endcase
    end
  end

  // FSM, timers and LED register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      mode_q      <= 2'd0;
      auto_cnt_q  <= '0;
      blank_cnt_q <= '0;
      led_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      auto_cnt_q  <= auto_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      led_q       <= led_d;
    end
  end

  //--------------------------------------------------------------------------
  // Outputs: idle drivers are held in reset so the selected pattern always
  // restarts from its beginning; in BLANK every driver is held.
  //--------------------------------------------------------------------------
  assign led_bus.led_out    = led_q;
  assign led_bus.mode_sel   = mode_q;
  assign led_bus.busy       = (state_q == ST_BLANK);
  assign led_bus.mode_rst_n = (state_q == ST_RUN) ? (4'b0001 << mode_q) : 4'b0000;

endmodule : led_mode_sequencer
`default_nettype wire
